// File: rtl/pwr_alu_pipe_if.sv
// Operand/result handshake bundle for pwr_alu_pipe.
// Upstream side: in_valid/in_ready with operands a, b and opcode ctrl.
// Downstream side: out_valid/out_ready with result s and flags zero/neg/ovf/illegal.
// The master modport is the environment (fetch + writeback); the slave modport is the ALU stage.
interface pwr_alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic             illegal;

  modport master (
    output in_valid, a, b, ctrl, out_ready,
    input  in_ready, out_valid, s, zero, neg, ovf, illegal
  );

  modport slave (
    input  in_valid, a, b, ctrl, out_ready,
    output in_ready, out_valid, s, zero, neg, ovf, illegal
  );
endinterface

// File: rtl/pwr_alu_pipe.sv
// Purpose: signed WIDTH-bit logic/arith/compare ALU with one registered output stage,
//          sticky overflow and accepted-operation counter.
// Latency: 1 cycle (result valid after the accepting edge); one op per cycle throughput.
// Backpressure: in_ready = !out_valid | out_ready; result/flags hold while stalled.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bus (slave)       operand handshake in, result handshake out (see pwr_alu_pipe_if)
//   clr_sticky        clears ovf_sticky (an accept with overflow in the same cycle wins)
//   ovf_sticky        OR of ovf over accepted ops since reset/clear
//   op_count          accepted-op counter, wraps modulo 2^CNT_W
// Option: define PWR_ALU_SAT_EN to saturate ops 3/4/12/13 on overflow instead of wrapping.
module pwr_alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  pwr_alu_pipe_if.slave       bus,
  input  logic                clr_sticky,
  output logic                ovf_sticky,
  output logic [CNT_W-1:0]    op_count
);

  localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]   ONE_X = {{WIDTH{1'b0}}, 1'b1};

  // Opcodes
  localparam logic [3:0] OP_PASS = 4'd2;
  localparam logic [3:0] OP_INC  = 4'd3;
  localparam logic [3:0] OP_DEC  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_XNOR = 4'd8;
  localparam logic [3:0] OP_GT   = 4'd9;
  localparam logic [3:0] OP_LT   = 4'd10;
  localparam logic [3:0] OP_EQ   = 4'd11;
  localparam logic [3:0] OP_ADD  = 4'd12;
  localparam logic [3:0] OP_SUB  = 4'd13;

  // Result register and flags
  logic [WIDTH-1:0] s_q, s_d;
  logic             zero_q, neg_q, ovf_q, ovf_d, ill_q, ill_d;
  logic             vld_q, vld_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Datapath intermediates
  logic [WIDTH:0]   a_x, b_x, ar_sum;
  logic [WIDTH-1:0] res;
  logic             is_ar;
  logic             accept;

  assign bus.in_ready = !vld_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // One guard bit of sign extension: the true signed result of every
  // arithmetic op fits in WIDTH+1 bits, so overflow is simply the guard
  // bit disagreeing with the WIDTH-bit sign bit.
  assign a_x = {bus.a[WIDTH-1], bus.a};
  assign b_x = {bus.b[WIDTH-1], bus.b};

  always_comb begin
    ar_sum = '0;
    is_ar  = 1'b0;
    res    = '0;
    ill_d  = 1'b0;
    case (bus.ctrl)
      OP_PASS: res = bus.a;
      OP_INC:  begin ar_sum = a_x + ONE_X; is_ar = 1'b1; end
      OP_DEC:  begin ar_sum = a_x - ONE_X; is_ar = 1'b1; end
      OP_NOT:  res = ~bus.a;
      OP_NOR:  res = ~(bus.a | bus.b);
      OP_XOR:  res = bus.a ^ bus.b;
      OP_XNOR: res = ~(bus.a ^ bus.b);
      OP_GT:   res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) > $signed(bus.b))};
      OP_LT:   res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_EQ:   res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
      OP_ADD:  begin ar_sum = a_x + b_x; is_ar = 1'b1; end
      OP_SUB:  begin ar_sum = a_x - b_x; is_ar = 1'b1; end
      default: ill_d = 1'b1;
    endcase
    if (is_ar) begin
      res = ar_sum[WIDTH-1:0];
    end
  end

  assign ovf_d = is_ar && (ar_sum[WIDTH] ^ ar_sum[WIDTH-1]);

  // The guard bit carries the sign of the true result, so it picks the clamp direction.
`ifdef PWR_ALU_SAT_EN
  assign s_d = ovf_d ? (ar_sum[WIDTH] ? S_MIN : S_MAX) : res;
`else
  assign s_d = res;
`endif

  // Next-state for the handshake, sticky flag and counter
  always_comb begin
    vld_d    = vld_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (accept) begin
      vld_d = 1'b1;
      cnt_d = cnt_q + CNT_W'(1);
    end else if (bus.out_ready) begin
      vld_d = 1'b0;
    end
    // An overflowing accept beats a same-cycle clear.
    if (accept && ovf_d) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= 1'b0;
      s_q      <= '0;
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      // Result and flags load only on accept; they hold through stalls and after consume.
      if (accept) begin
        s_q    <= s_d;
        zero_q <= (s_d == '0);
        neg_q  <= s_d[WIDTH-1];
        ovf_q  <= ovf_d;
        ill_q  <= ill_d;
      end
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.s         = s_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;
  assign bus.illegal   = ill_q;
  assign ovf_sticky    = sticky_q;
  assign op_count      = cnt_q;

endmodule

// File: tb/tb_pwr_alu_pipe.sv
// Self-checking bench for pwr_alu_pipe (WIDTH=8, CNT_W=16): directed cases plus
// randomized traffic, every cycle checked against an integer-arithmetic reference model.
module tb_pwr_alu_pipe;
  localparam int W  = 8;
  localparam int CW = 16;
`ifdef PWR_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_sticky;
  logic          ovf_sticky;
  logic [CW-1:0] op_count;

  pwr_alu_pipe_if #(.WIDTH(W)) bus ();

  pwr_alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clr_sticky (clr_sticky),
    .ovf_sticky (ovf_sticky),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state
  logic [W-1:0]  m_s      = '0;
  bit            m_vld    = 0;
  bit            m_ovf    = 0;
  bit            m_ill    = 0;
  bit            m_sticky = 0;
  int unsigned   m_cnt    = 0;

  // Behavioural ALU: true signed result in plain integers, then range check.
  function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] s, output bit ov, output bit il);
    int sa, sb, t, lo, hi;
    bit arith;
    sa = $signed(a);
    sb = $signed(b);
    lo = -(1 << (W-1));
    hi = (1 << (W-1)) - 1;
    t = 0; arith = 0; il = 0; ov = 0;
    case (op)
      4'd2:  t = sa;
      4'd3:  begin t = sa + 1;  arith = 1; end
      4'd4:  begin t = sa - 1;  arith = 1; end
      4'd5:  t = ~sa;
      4'd6:  t = ~(sa | sb);
      4'd7:  t = sa ^ sb;
      4'd8:  t = ~(sa ^ sb);
      4'd9:  t = (sa > sb)  ? 1 : 0;
      4'd10: t = (sa < sb)  ? 1 : 0;
      4'd11: t = (sa == sb) ? 1 : 0;
      4'd12: begin t = sa + sb; arith = 1; end
      4'd13: begin t = sa - sb; arith = 1; end
      default: il = 1;
    endcase
    if (arith && (t > hi || t < lo)) begin
      ov = 1;
      if (SAT) t = (t > hi) ? hi : lo;
    end
    s = t[W-1:0];
  endfunction

  // One clock: check in_ready before the edge, advance the model, check all outputs after it.
  task automatic tick();
    bit          acc;
    logic [W-1:0] rs;
    bit          rov, ril;
    @(negedge clk);
    if (!rst) chk("in_ready", {31'b0, bus.in_ready}, {31'b0, (!m_vld || bus.out_ready)});
    acc = bus.in_valid && (!m_vld || bus.out_ready);
    ref_op(bus.ctrl, bus.a, bus.b, rs, rov, ril);
    @(posedge clk);
    if (rst) begin
      m_vld = 0; m_s = '0; m_ovf = 0; m_ill = 0; m_sticky = 0; m_cnt = 0;
    end else begin
      if (acc) begin
        m_vld = 1; m_s = rs; m_ovf = rov; m_ill = ril;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end else if (bus.out_ready) begin
        m_vld = 0;
      end
      if (acc && rov) m_sticky = 1;
      else if (clr_sticky) m_sticky = 0;
    end
    #1;
    chk("out_valid",  {31'b0, bus.out_valid}, {31'b0, m_vld});
    chk("s",          {24'b0, bus.s},         {24'b0, m_s});
    chk("zero",       {31'b0, bus.zero},      {31'b0, (m_s == 0)});
    chk("neg",        {31'b0, bus.neg},       {31'b0, m_s[W-1]});
    chk("ovf",        {31'b0, bus.ovf},       {31'b0, m_ovf});
    chk("illegal",    {31'b0, bus.illegal},   {31'b0, m_ill});
    chk("ovf_sticky", {31'b0, ovf_sticky},    {31'b0, m_sticky});
    chk("op_count",   {16'b0, op_count},      m_cnt);
  endtask

  task automatic drive(input bit v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit ordy, input bit clr);
    bus.in_valid  = v;
    bus.ctrl      = op;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = ordy;
    clr_sticky    = clr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 4'd0, 8'h00, 8'h00, 1, 0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_zero",      {31'b0, bus.zero},      32'd1);
    chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);

    // Increment of max positive
    drive(1, 4'd3, 8'd127, 8'h00, 1, 0); tick();
    chk("inc127_s",   {24'b0, bus.s}, SAT ? 32'h7F : 32'h80);
    chk("inc127_ovf", {31'b0, bus.ovf}, 32'd1);
    chk("inc127_neg", {31'b0, bus.neg}, SAT ? 32'd0 : 32'd1);
    chk("inc127_sticky", {31'b0, ovf_sticky}, 32'd1);

    // Subtract from most negative
    drive(1, 4'd13, 8'h80, 8'h01, 1, 0); tick();
    chk("sub_min_s",   {24'b0, bus.s}, SAT ? 32'h80 : 32'h7F);
    chk("sub_min_ovf", {31'b0, bus.ovf}, 32'd1);

    // Signed compares
    drive(1, 4'd9, 8'hFF, 8'h01, 1, 0); tick();
    chk("gt_s",    {24'b0, bus.s}, 32'd0);
    chk("gt_zero", {31'b0, bus.zero}, 32'd1);
    drive(1, 4'd10, 8'hFF, 8'h01, 1, 0); tick();
    chk("lt_s",    {24'b0, bus.s}, 32'd1);

    // Backpressure: result holds, no further accepts
    do_reset();
    drive(1, 4'd7, 8'hF0, 8'hFF, 0, 0); tick();
    drive(1, 4'd12, 8'h11, 8'h22, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_s",        {24'b0, bus.s}, 32'h0F);
      chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("bp_count",    {16'b0, op_count}, 32'd1);
    end
    drive(1, 4'd12, 8'h11, 8'h22, 1, 0); tick();
    chk("bp_b2b_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("bp_b2b_s",     {24'b0, bus.s}, 32'h33);
    chk("bp_b2b_count", {16'b0, op_count}, 32'd2);

    // Streaming: 10 back-to-back ops
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 4'(2 + (i % 12)), 8'($urandom), 8'($urandom), 1, 0);
      tick();
      chk("stream_valid", {31'b0, bus.out_valid}, 32'd1);
    end
    chk("stream_count", {16'b0, op_count}, 32'd10);
    drive(1, 4'd14, 8'h55, 8'hAA, 1, 0); tick();
    chk("ill_s",     {24'b0, bus.s}, 32'd0);
    chk("ill_flag",  {31'b0, bus.illegal}, 32'd1);
    chk("ill_count", {16'b0, op_count}, 32'd11);

    // Sticky: set beats same-cycle clear, then a lone clear drops it
    drive(1, 4'd12, 8'h7F, 8'h01, 1, 1); tick();
    chk("sticky_set_wins", {31'b0, ovf_sticky}, 32'd1);
    drive(0, 4'd2, 8'h00, 8'h00, 1, 1); tick();
    chk("sticky_clr", {31'b0, ovf_sticky}, 32'd0);

    // Reset while stalled with a pending result
    drive(1, 4'd2, 8'h5A, 8'h00, 0, 0); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_bp_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_bp_s",     {24'b0, bus.s}, 32'd0);
    chk("rst_bp_zero",  {31'b0, bus.zero}, 32'd1);
    chk("rst_bp_count", {16'b0, op_count}, 32'd0);
    chk("rst_bp_rdy",   {31'b0, bus.in_ready}, 32'd1);
    drive(0, 4'd0, 8'h00, 8'h00, 1, 0);

    // Randomized traffic with random stalls, clears and occasional reset
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) bus.a = ($urandom_range(0, 1) != 0) ? 8'h7F : 8'h80;
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
